// File: rtl/tfe_seq_pkg.sv
// Shared types and constants for the TensorFlowE host sequencer.
package tfe_seq_pkg;

  localparam int unsigned CNT_W = 8;

  typedef logic [7:0] byte_t;

  typedef enum logic [3:0] {
    StIdle,
    StClear,
    StLoad,
    StWrite,
    StAcc,
    StOut,
    StWait,
    StPresent,
    StDone
  } state_e;

endpackage

// File: rtl/tfe_host_sequencer.sv
// Host-side initiator for the TensorFlowE byte interface: streams operands in, reads results out.
// Optional TFE_SEQ_CHECKSUM_EN appends one XOR-of-results beat per job.
module tfe_host_sequencer #(
  parameter int unsigned VEC_LEN  = 4,
  parameter int unsigned RES_LEN  = 1,
  parameter int unsigned READ_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic [7:0] core_datos_in,
  output logic       core_ena_write,
  output logic       core_ena_read,
  output logic       core_clear,
  output logic       core_enable_accu,
  output logic       core_ena_out,
  input  logic [7:0] core_datos_out
);
  import tfe_seq_pkg::*;

  localparam logic [CNT_W-1:0] VecLast = CNT_W'(VEC_LEN - 1);
  localparam logic [CNT_W-1:0] ResLast = CNT_W'(RES_LEN - 1);
  localparam logic [2:0]       LatLast = 3'(READ_LAT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] e_q, e_d;
  logic [CNT_W-1:0] r_q, r_d;
  logic [2:0]       wait_q, wait_d;
  byte_t            datos_in_d;
  byte_t            m_data_d;

`ifdef TFE_SEQ_CHECKSUM_EN
  byte_t            csum_q, csum_d;
  logic             csum_beat_q, csum_beat_d;
`endif

  always_comb begin
    state_d    = state_q;
    e_d        = e_q;
    r_d        = r_q;
    wait_d     = wait_q;
    datos_in_d = core_datos_in;
    m_data_d   = m_data;
`ifdef TFE_SEQ_CHECKSUM_EN
    csum_d      = csum_q;
    csum_beat_d = csum_beat_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StClear;
      end
      StClear: begin
        e_d     = '0;
        r_d     = '0;
        state_d = StLoad;
`ifdef TFE_SEQ_CHECKSUM_EN
        csum_d      = '0;
        csum_beat_d = 1'b0;
`endif
      end
      StLoad: begin
        if (s_valid && s_ready) begin
          datos_in_d = s_data;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        state_d = StAcc;
      end
      StAcc: begin
        e_d     = e_q + 8'd1;
        state_d = (e_q == VecLast) ? StOut : StLoad;
      end
      StOut: begin
        // With zero latency the core output is already valid while ena_out is first high.
        if (READ_LAT == 0) begin
          m_data_d = core_datos_out;
          state_d  = StPresent;
`ifdef TFE_SEQ_CHECKSUM_EN
          csum_d   = csum_q ^ core_datos_out;
`endif
        end else begin
          wait_d  = 3'd1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (wait_q == LatLast) begin
          m_data_d = core_datos_out;
          state_d  = StPresent;
`ifdef TFE_SEQ_CHECKSUM_EN
          csum_d   = csum_q ^ core_datos_out;
`endif
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      StPresent: begin
        if (m_valid && m_ready) begin
`ifdef TFE_SEQ_CHECKSUM_EN
          if (csum_beat_q) begin
            state_d = StDone;
          end else begin
            r_d = r_q + 8'd1;
            if (r_q == ResLast) begin
              csum_beat_d = 1'b1;
              m_data_d    = csum_q;
            end else begin
              state_d = StOut;
            end
          end
`else
          r_d     = r_q + 8'd1;
          state_d = (r_q == ResLast) ? StDone : StOut;
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      e_q              <= '0;
      r_q              <= '0;
      wait_q           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      s_ready          <= 1'b0;
      m_valid          <= 1'b0;
      m_data           <= '0;
      core_datos_in    <= '0;
      core_ena_write   <= 1'b0;
      core_ena_read    <= 1'b0;
      core_clear       <= 1'b0;
      core_enable_accu <= 1'b0;
      core_ena_out     <= 1'b0;
`ifdef TFE_SEQ_CHECKSUM_EN
      csum_q           <= '0;
      csum_beat_q      <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      e_q              <= e_d;
      r_q              <= r_d;
      wait_q           <= wait_d;
      busy             <= (state_d != StIdle);
      done             <= (state_d == StDone);
      s_ready          <= (state_d == StLoad);
      m_valid          <= (state_d == StPresent);
      m_data           <= m_data_d;
      core_datos_in    <= datos_in_d;
      core_ena_write   <= (state_d == StWrite);
      core_ena_read    <= (state_d == StAcc);
      core_clear       <= (state_d == StClear);
      core_enable_accu <= (state_d == StAcc);
      core_ena_out     <= (state_d == StOut) || (state_d == StWait);
`ifdef TFE_SEQ_CHECKSUM_EN
      csum_q           <= csum_d;
      csum_beat_q      <= csum_beat_d;
`endif
    end
  end

endmodule
